// File: rtl/z80_io_responder_if.sv
// Z80 I/O bus, TX byte stream and RX byte stream seen by the I/O responder.
// The slave modport is the responder; the master modport is the CPU/consumer/producer side.
interface z80_io_responder_if;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic       m1_n;
  logic       wait_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport slave (
    input  addr, data_in, iorq_n, rd_n, wr_n, m1_n, tx_ready, rx_data, rx_valid,
    output data_out, data_oe, wait_n, tx_data, tx_valid, rx_ready
  );

  modport master (
    output addr, data_in, iorq_n, rd_n, wr_n, m1_n, tx_ready, rx_data, rx_valid,
    input  data_out, data_oe, wait_n, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/z80_io_responder.sv
// Z80 I/O-space responder: data port at BASE_ADDR feeds a TX FIFO / reads an RX holding
// register, status port at BASE_ADDR+1; WAIT is asserted while writing into a full FIFO.
module z80_io_responder #(
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter int         FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  z80_io_responder_if.slave bus
);
  localparam int             PW       = $clog2(FIFO_DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, STALL} state_t;

  state_t        state_q, state_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_oe_q, data_oe_d;
  logic          wait_n_q, wait_n_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rx_full_q, rx_full_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic       sel, rd_strb, wr_strb;
  logic       fifo_full, tx_valid, pop, push, rd_clear, rx_cap;
  logic [7:0] push_byte;

  // Interrupt acknowledge (IORQ and M1 both low) never selects the device.
  assign sel       = (bus.addr[7:1] == BASE_ADDR[7:1]) & ~bus.iorq_n & bus.m1_n;
  assign rd_strb   = sel & ~bus.rd_n;
  assign wr_strb   = sel & ~bus.wr_n;
  assign fifo_full = (count_q == FULL_CNT);
  assign tx_valid  = (count_q != '0);
  assign pop       = tx_valid & bus.tx_ready;
  assign rx_cap    = bus.rx_valid & ~rx_full_q;

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    wait_n_d   = wait_n_q;
    wdata_d    = wdata_q;
    push       = 1'b0;
    push_byte  = bus.data_in;
    rd_clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_strb) begin
          data_oe_d = 1'b1;
          state_d   = ACCESS;
          if (!bus.addr[0]) begin
            data_out_d = rx_full_q ? rx_byte_q : 8'h00;
            rd_clear   = rx_full_q;
          end else begin
            data_out_d = {6'b0, rx_full_q, ~fifo_full};
          end
        end else if (wr_strb) begin
          if (bus.addr[0]) begin
            state_d = ACCESS;
          end else if (!fifo_full) begin
            push    = 1'b1;
            state_d = ACCESS;
          end else begin
            wait_n_d = 1'b0;
            wdata_d  = bus.data_in;
            state_d  = STALL;
          end
        end
      end
      // A pop on the same edge only frees the slot from the next edge on.
      STALL: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_byte = wdata_q;
          wait_n_d  = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (!rd_strb && !wr_strb) begin
          data_oe_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Capture only happens when empty, so it never collides with a clearing read.
    if (rd_clear) rx_full_d = 1'b0;
    if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_byte_d = bus.rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      wait_n_q   <= 1'b1;
      wdata_q    <= 8'h00;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      wait_n_q   <= wait_n_d;
      wdata_q    <= wdata_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_byte;
  end

  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;
  assign bus.wait_n   = wait_n_q;
  assign bus.tx_data  = mem_q[rd_ptr_q];
  assign bus.tx_valid = tx_valid;
  assign bus.rx_ready = ~rx_full_q;
endmodule
